// File: rtl/fsx_pkg.sv
// Shared types and helpers for the Frame Synthesizer video timing path.
// The sync bundle carries asserted-sense flags; pin polarity is applied at the top.
package fsx_pkg;

  localparam logic [1:0] SCALE_1X = 2'b00;
  localparam logic [1:0] SCALE_2X = 2'b01;
  localparam logic [1:0] SCALE_4X = 2'b10;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic csync;
    logic blank;
  } sync_bundle_t;

  localparam sync_bundle_t SYNC_IDLE = '{hsync: 1'b0, vsync: 1'b0, csync: 1'b0, blank: 1'b1};

  function automatic int unsigned calc_total(input int unsigned active_len,
                                             input int unsigned fp_len,
                                             input int unsigned sync_len,
                                             input int unsigned bp_len);
    return active_len + fp_len + sync_len + bp_len;
  endfunction

  // Encoding 11 is treated as 1x so an unused code never produces a wild shift.
  function automatic logic [1:0] scale_shift(input logic [1:0] sel);
    logic [1:0] sh;
    case (sel)
      SCALE_2X: sh = 2'd1;
      SCALE_4X: sh = 2'd2;
      default:  sh = 2'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/video_sig_delay.sv
// Fixed-depth shift register for sideband signals; every stage resets and
// flushes to a common idle value so the output never shows stale sync.
module video_sig_delay #(
  parameter int               DEPTH = 2,
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset, flush};
      assign q = d;
    end else begin : g_pipe
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] stage_reg;
        logic [WIDTH-1:0] stage_next;

        if (gi == 0) begin : g_first
          assign stage_next = d;
        end else begin : g_chain
          assign stage_next = g_stage[gi-1].stage_reg;
        end

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            stage_reg <= IDLE;
          end else if (flush) begin
            stage_reg <= IDLE;
          end else begin
            stage_reg <= stage_next;
          end
        end
      end
      assign q = g_stage[DEPTH-1].stage_reg;
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Generic raster timing engine: position counters, scaled framebuffer coordinate,
// sync/blank delayed to match renderer latency, and line/frame pulses.
module video_timing_gen
  import fsx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 12,
  parameter int PIPE     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       scale_sel,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y,
  output logic             px_valid,
  output logic             hsync,
  output logic             vsync,
  output logic             csync,
  output logic             blank,
  output logic             line_start,
  output logic             frame_drawn
);

  localparam int H_TOTAL = int'(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int V_TOTAL = int'(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

  generate
    if (H_TOTAL >= 2**CNT_W) begin : g_err_h
      $error("video_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL >= 2**CNT_W) begin : g_err_v
      $error("video_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
    if (PIPE > 15 || PIPE < 0) begin : g_err_pipe
      $error("video_timing_gen: PIPE must be in 0..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic             SYNC_ON    = (SYNC_POL != 0);

  logic [CNT_W-1:0] h_count_reg, h_count_next;
  logic [CNT_W-1:0] v_count_reg, v_count_next;
  logic             active_reg, active_next;
  logic [1:0]       scale_reg, scale_next;

  logic             h_last;
  logic             v_last;
  logic             px_valid_int;
  logic [1:0]       shift_amt;
  sync_bundle_t     bundle_in;
  sync_bundle_t     bundle_out;

  assign h_last = (h_count_reg == H_LAST);
  assign v_last = (v_count_reg == V_LAST);

  // active_reg marks that counting has started; the first enabled edge after
  // idle only arms it, so the raster restarts cleanly at (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count_reg <= '0;
      v_count_reg <= '0;
      active_reg  <= 1'b0;
      scale_reg   <= SCALE_1X;
    end else begin
      h_count_reg <= h_count_next;
      v_count_reg <= v_count_next;
      active_reg  <= active_next;
      scale_reg   <= scale_next;
    end
  end

  always_comb begin
    h_count_next = h_count_reg;
    v_count_next = v_count_reg;
    active_next  = active_reg;
    scale_next   = scale_reg;
    if (!enable) begin
      h_count_next = '0;
      v_count_next = '0;
      active_next  = 1'b0;
      scale_next   = scale_sel;
    end else if (!active_reg) begin
      active_next = 1'b1;
      scale_next  = scale_sel;
    end else if (h_last) begin
      h_count_next = '0;
      if (v_last) begin
        v_count_next = '0;
        // Scale only changes on the frame boundary so a frame never tears.
        scale_next   = scale_sel;
      end else begin
        v_count_next = v_count_reg + 1'b1;
      end
    end else begin
      h_count_next = h_count_reg + 1'b1;
    end
  end

  assign px_valid_int = active_reg && (h_count_reg < H_ACT) && (v_count_reg < V_ACT);
  assign shift_amt    = scale_shift(scale_reg);

  assign h_count  = h_count_reg;
  assign v_count  = v_count_reg;
  assign px_valid = px_valid_int;
  assign px_x     = px_valid_int ? (h_count_reg >> shift_amt) : '0;
  assign px_y     = px_valid_int ? (v_count_reg >> shift_amt) : '0;

  assign line_start  = enable && active_reg && (h_count_reg == '0);
  assign frame_drawn = enable && active_reg && h_last && (v_count_reg == V_ACT_LAST);

  always_comb begin
    bundle_in = SYNC_IDLE;
    if (active_reg) begin
      bundle_in.hsync = (h_count_reg >= HS_FIRST) && (h_count_reg <= HS_LAST);
      bundle_in.vsync = (v_count_reg >= VS_FIRST) && (v_count_reg <= VS_LAST);
      bundle_in.csync = bundle_in.hsync ^ bundle_in.vsync;
      bundle_in.blank = ~px_valid_int;
    end
  end

  video_sig_delay #(
    .DEPTH (PIPE),
    .WIDTH ($bits(sync_bundle_t)),
    .IDLE  (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .flush (~enable),
    .d     (bundle_in),
    .q     (bundle_out)
  );

  assign hsync = bundle_out.hsync ? SYNC_ON : ~SYNC_ON;
  assign vsync = bundle_out.vsync ? SYNC_ON : ~SYNC_ON;
  assign csync = bundle_out.csync ? SYNC_ON : ~SYNC_ON;
  assign blank = bundle_out.blank;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 16x8 raster, PIPE=2 and PIPE=0 instances.
module tb_video_timing_gen;

  localparam int CW = 12;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [1:0] scale_sel;

  logic [CW-1:0] a_h_count, a_v_count, a_px_x, a_px_y;
  logic a_px_valid, a_hsync, a_vsync, a_csync, a_blank, a_line_start, a_frame_drawn;
  logic [CW-1:0] z_h_count, z_v_count, z_px_x, z_px_y;
  logic z_px_valid, z_hsync, z_vsync, z_csync, z_blank, z_line_start, z_frame_drawn;

  int n_cmp = 0;
  int n_fail = 0;
  int ls_cnt = 0;
  int fd_cnt = 0;

  // Reference raster state: act/hm/vm/sc mirror the expected generator state,
  // s1/s2 the expected delay stages as {hs, vs, cs, blank} asserted flags.
  bit         act;
  int         hm, vm;
  logic [1:0] sc;
  logic [3:0] s1, s2;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(0), .CNT_W(CW), .PIPE(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .scale_sel(scale_sel),
    .h_count(a_h_count), .v_count(a_v_count), .px_x(a_px_x), .px_y(a_px_y),
    .px_valid(a_px_valid), .hsync(a_hsync), .vsync(a_vsync), .csync(a_csync),
    .blank(a_blank), .line_start(a_line_start), .frame_drawn(a_frame_drawn)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(0), .CNT_W(CW), .PIPE(0)
  ) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .scale_sel(scale_sel),
    .h_count(z_h_count), .v_count(z_v_count), .px_x(z_px_x), .px_y(z_px_y),
    .px_valid(z_px_valid), .hsync(z_hsync), .vsync(z_vsync), .csync(z_csync),
    .blank(z_blank), .line_start(z_line_start), .frame_drawn(z_frame_drawn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (model h=%0d v=%0d)", tag, obs, exp, hm, vm);
    end
  endtask

  function automatic logic [3:0] model_bundle();
    logic hs, vs, pv;
    if (!act) return 4'b0001;
    hs = (hm >= 10) && (hm <= 12);
    vs = (vm >= 5) && (vm <= 6);
    pv = (hm < 8) && (vm < 4);
    return {hs, vs, hs ^ vs, ~pv};
  endfunction

  task automatic check_now();
    logic [3:0] cur;
    logic pv, ls, fd;
    logic e_hs, e_vs, e_cs, e_bl, c_hs, c_vs, c_cs, c_bl;
    int sh, ex, ey;
    cur = model_bundle();
    pv  = act && (hm < 8) && (vm < 4);
    ls  = enable && act && (hm == 0);
    fd  = enable && act && (hm == 15) && (vm == 3);
    sh  = (sc == 2'b01) ? 1 : (sc == 2'b10) ? 2 : 0;
    ex  = pv ? (hm >> sh) : 0;
    ey  = pv ? (vm >> sh) : 0;
    e_hs = ~s2[3]; e_vs = ~s2[2]; e_cs = ~s2[1]; e_bl = s2[0];
    c_hs = ~cur[3]; c_vs = ~cur[2]; c_cs = ~cur[1]; c_bl = cur[0];
    chk("h_count", a_h_count, hm);
    chk("v_count", a_v_count, vm);
    chk("px_valid", a_px_valid, pv);
    chk("px_x", a_px_x, ex);
    chk("px_y", a_px_y, ey);
    chk("line_start", a_line_start, ls);
    chk("frame_drawn", a_frame_drawn, fd);
    chk("hsync_p2", a_hsync, e_hs);
    chk("vsync_p2", a_vsync, e_vs);
    chk("csync_p2", a_csync, e_cs);
    chk("blank_p2", a_blank, e_bl);
    chk("h_count_p0", z_h_count, hm);
    chk("hsync_p0", z_hsync, c_hs);
    chk("vsync_p0", z_vsync, c_vs);
    chk("csync_p0", z_csync, c_cs);
    chk("blank_p0", z_blank, c_bl);
    ls_cnt += int'(a_line_start);
    fd_cnt += int'(a_frame_drawn);
  endtask

  task automatic advance();
    logic [3:0] cur;
    cur = model_bundle();
    if (!enable) begin
      act = 0; hm = 0; vm = 0; sc = scale_sel; s1 = 4'b0001; s2 = 4'b0001;
    end else begin
      s2 = s1;
      s1 = cur;
      if (!act) begin
        act = 1; sc = scale_sel;
      end else if (hm == 15) begin
        hm = 0;
        if (vm == 7) begin vm = 0; sc = scale_sel; end
        else vm = vm + 1;
      end else begin
        hm = hm + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int th, input int tv);
    int guard;
    guard = 0;
    while (!(act && hm == th && vm == tv)) begin
      check_now();
      advance();
      guard++;
      if (guard > 300) begin
        n_cmp++;
        n_fail++;
        $error("FAIL run_to: observed no arrival expected h=%0d v=%0d within 300 cycles", th, tv);
        return;
      end
    end
  endtask

  task automatic model_reset();
    act = 0; hm = 0; vm = 0; sc = 2'b00; s1 = 4'b0001; s2 = 4'b0001;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    scale_sel = 2'b00;
    model_reset();
    @(posedge clk);
    #1;
    $display("step reset_state");
    chk("rst_h_count", a_h_count, 0);
    chk("rst_v_count", a_v_count, 0);
    chk("rst_px_valid", a_px_valid, 0);
    chk("rst_hsync", a_hsync, 1);
    chk("rst_vsync", a_vsync, 1);
    chk("rst_csync", a_csync, 1);
    chk("rst_blank", a_blank, 1);
    chk("rst_line_start", a_line_start, 0);
    chk("rst_frame_drawn", a_frame_drawn, 0);

    reset = 1'b0;
    enable = 1'b1;
    check_now();
    advance();
    $display("step first_active h=%0d v=%0d", a_h_count, a_v_count);
    chk("start_h", a_h_count, 0);
    chk("start_line_start", a_line_start, 1);
    chk("start_blank_pipe", a_blank, 1);

    scale_sel = 2'b01;  // mid-frame: must not affect this frame

    run_to(8, 0);
    $display("step blank_edge h=8");
    chk("h8_px_valid", a_px_valid, 0);
    chk("h8_px_x", a_px_x, 0);
    run_to(9, 0);
    chk("h9_blank", a_blank, 0);
    run_to(10, 0);
    $display("step hsync_start h=10");
    chk("h10_blank", a_blank, 1);
    chk("h10_hsync_p2", a_hsync, 1);
    chk("h10_hsync_p0", z_hsync, 0);
    run_to(12, 0);
    chk("h12_hsync_p2", a_hsync, 0);
    run_to(15, 0);
    chk("h15_hsync_p2", a_hsync, 1);
    run_to(1, 1);
    chk("l1h1_blank", a_blank, 1);
    run_to(2, 1);
    chk("l1h2_blank", a_blank, 0);

    run_to(5, 3);
    $display("step scale_1x (5,3)");
    chk("f1_px_x", a_px_x, 5);
    chk("f1_px_y", a_px_y, 3);
    run_to(15, 3);
    chk("f1_frame_drawn", a_frame_drawn, 1);
    run_to(2, 5);
    $display("step vsync (2,5)");
    chk("v5_vsync", a_vsync, 0);
    chk("v5_csync", a_csync, 0);
    run_to(12, 5);
    chk("v5h12_hsync", a_hsync, 0);
    chk("v5h12_csync", a_csync, 1);

    run_to(0, 0);
    ls_cnt = 0;
    fd_cnt = 0;
    run_to(0, 1);
    scale_sel = 2'b10;  // mid-frame change to 4x
    run_to(5, 3);
    $display("step scale_2x (5,3)");
    chk("f2_px_x", a_px_x, 2);
    chk("f2_px_y", a_px_y, 1);
    run_to(0, 0);
    $display("step frame_pulses line_start=%0d frame_drawn=%0d", ls_cnt, fd_cnt);
    chk("line_start_per_frame", ls_cnt, 8);
    chk("frame_drawn_per_frame", fd_cnt, 1);
    run_to(5, 3);
    $display("step scale_4x (5,3)");
    chk("f3_px_x", a_px_x, 1);
    chk("f3_px_y", a_px_y, 0);

    run_to(6, 2);
    reset = 1'b1;
    #1;
    $display("step async_reset at (6,2)");
    chk("ar_h_count", a_h_count, 0);
    chk("ar_v_count", a_v_count, 0);
    chk("ar_px_valid", a_px_valid, 0);
    chk("ar_px_x", a_px_x, 0);
    chk("ar_hsync", a_hsync, 1);
    chk("ar_vsync", a_vsync, 1);
    chk("ar_csync", a_csync, 1);
    chk("ar_blank", a_blank, 1);
    chk("ar_blank_p0", z_blank, 1);
    chk("ar_line_start", a_line_start, 0);
    model_reset();
    #1;
    reset = 1'b0;

    run_to(3, 1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_now();
      advance();
    end
    $display("step idle after enable low");
    chk("idle_h", a_h_count, 0);
    chk("idle_v", a_v_count, 0);
    chk("idle_blank", a_blank, 1);
    chk("idle_hsync", a_hsync, 1);
    chk("idle_line_start", a_line_start, 0);
    enable = 1'b1;
    check_now();
    advance();
    $display("step restart h=%0d v=%0d", a_h_count, a_v_count);
    chk("re_h", a_h_count, 0);
    chk("re_line_start", a_line_start, 1);
    chk("re_px_valid", a_px_valid, 1);
    run_to(0, 1);
    check_now();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
